// File: rtl/ex_forward_unit_if.sv
// ---------------------------------------------------------------------------
// ex_forward_unit_if
//
// Bundles the ID-stage instruction description and the forwarding/hazard
// results exchanged between the decode logic and ex_forward_unit.
//
// Signals:
//   inIdRs / inIdRt          source specifiers of the instruction in ID
//   inIdUsesRs / inIdUsesRt  the ID instruction actually reads that source
//   inIdRd                   resolved destination of the ID instruction
//   inIdRegWrite             the ID instruction writes the register file
//   inIdMemRead              the ID instruction is a load
//   inFlush                  kill the ID instruction (taken branch)
//   outForwardA / B          registered EX operand mux selects
//                            (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   outStall                 combinational load-use stall request
//   outBubble                EX currently holds a bubble / flushed slot
//   outStallCount            saturating stall-cycle counter
//
// Modports:
//   master  decode side (drives the ID description, observes results)
//   slave   the forwarding unit itself
// ---------------------------------------------------------------------------
interface ex_forward_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
);
    logic [REG_BITS-1:0] inIdRs;
    logic [REG_BITS-1:0] inIdRt;
    logic                inIdUsesRs;
    logic                inIdUsesRt;
    logic [REG_BITS-1:0] inIdRd;
    logic                inIdRegWrite;
    logic                inIdMemRead;
    logic                inFlush;
    logic [1:0]          outForwardA;
    logic [1:0]          outForwardB;
    logic                outStall;
    logic                outBubble;
    logic [CNT_BITS-1:0] outStallCount;

    modport master (
        output inIdRs,
        output inIdRt,
        output inIdUsesRs,
        output inIdUsesRt,
        output inIdRd,
        output inIdRegWrite,
        output inIdMemRead,
        output inFlush,
        input  outForwardA,
        input  outForwardB,
        input  outStall,
        input  outBubble,
        input  outStallCount
    );

    modport slave (
        input  inIdRs,
        input  inIdRt,
        input  inIdUsesRs,
        input  inIdUsesRt,
        input  inIdRd,
        input  inIdRegWrite,
        input  inIdMemRead,
        input  inFlush,
        output outForwardA,
        output outForwardB,
        output outStall,
        output outBubble,
        output outStallCount
    );
endinterface

// File: rtl/ex_forward_unit.sv
// ---------------------------------------------------------------------------
// ex_forward_unit
//
// Forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
// The instruction sitting in ID is compared against shadow copies of the
// instructions currently in EX and MEM. The resulting operand selects are
// registered so they line up with the instruction as it enters EX.
// A load in EX whose destination is read by the ID instruction triggers a
// one-cycle stall: PC and IF/ID freeze while a bubble is pushed into EX.
// A taken branch (inFlush) kills the ID instruction and takes precedence
// over any stall request in the same cycle.
//
// Ports:
//   inClk    rising-edge clock
//   inReset  synchronous active-high reset
//   bus      ex_forward_unit_if.slave (ID description in, selects out)
// ---------------------------------------------------------------------------
module ex_forward_unit #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                  inClk,
    input  logic                  inReset,
    ex_forward_unit_if.slave      bus
);

    // Shadow of an in-flight instruction: just enough to decide forwarding.
    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } slot_t;

    localparam slot_t EMPTY_SLOT = '0;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EXMEM   = 2'b10;
    localparam logic [1:0] SEL_MEMWB   = 2'b01;

    // What the pipeline does at the next edge (reset is handled in the flops).
    typedef enum logic [1:0] {
        UPD_NORMAL,
        UPD_STALL,
        UPD_FLUSH
    } upd_e;

    slot_t               ex_slot_q,  ex_slot_d;
    slot_t               mem_slot_q, mem_slot_d;
    logic [1:0]          fwd_a_q,    fwd_a_d;
    logic [1:0]          fwd_b_q,    fwd_b_d;
    logic                bubble_q,   bubble_d;
    logic [CNT_BITS-1:0] count_q,    count_d;

    logic                hz;
    logic                rs_hit_ex;
    logic                rt_hit_ex;
    logic [1:0]          sel_a;
    logic [1:0]          sel_b;
    upd_e                upd_mode;

    // Operand select for one source. The EX-slot producer is younger, so it
    // wins over the MEM-slot producer; $0 is hard-wired and never forwards.
    // Anything older than MEM has already been written to the register file,
    // which writes before it reads.
    function automatic logic [1:0] fwd_sel(
        input logic                uses,
        input logic [REG_BITS-1:0] src,
        input slot_t               ex,
        input slot_t               mem
    );
        logic [1:0] sel;
        sel = SEL_REGFILE;
        if (uses && ex.reg_write && (ex.rd != '0) && (src == ex.rd)) begin
            sel = SEL_EXMEM;
        end else if (uses && mem.reg_write && (mem.rd != '0) && (src == mem.rd)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    // Load-use detection: the loaded value only exists after MEM, so an
    // instruction reading it directly behind the load must wait one cycle.
    always_comb begin
        rs_hit_ex = bus.inIdUsesRs && (bus.inIdRs == ex_slot_q.rd);
        rt_hit_ex = bus.inIdUsesRt && (bus.inIdRt == ex_slot_q.rd);
        hz        = ex_slot_q.mem_read && ex_slot_q.reg_write &&
                    (ex_slot_q.rd != '0) && (rs_hit_ex || rt_hit_ex);
    end

    // Forwarding selects for the ID instruction against the current slots.
    always_comb begin
        sel_a = fwd_sel(bus.inIdUsesRs, bus.inIdRs, ex_slot_q, mem_slot_q);
        sel_b = fwd_sel(bus.inIdUsesRt, bus.inIdRt, ex_slot_q, mem_slot_q);
    end

    // Flush beats stall: a killed instruction has no hazard to wait for.
    always_comb begin
        upd_mode = UPD_NORMAL;
        if (bus.inFlush) begin
            upd_mode = UPD_FLUSH;
        end else if (hz) begin
            upd_mode = UPD_STALL;
        end
    end

    // Next-state for slots, selects, bubble flag and the stall counter.
    // In both the stall and flush cases an empty slot enters EX while the
    // old EX instruction keeps moving down into MEM.
    always_comb begin
        ex_slot_d  = ex_slot_q;
        mem_slot_d = ex_slot_q;
        fwd_a_d    = fwd_a_q;
        fwd_b_d    = fwd_b_q;
        bubble_d   = bubble_q;
        count_d    = count_q;

        unique case (upd_mode)
            UPD_FLUSH: begin
                ex_slot_d = EMPTY_SLOT;
                fwd_a_d   = SEL_REGFILE;
                fwd_b_d   = SEL_REGFILE;
                bubble_d  = 1'b1;
            end
            UPD_STALL: begin
                ex_slot_d = EMPTY_SLOT;
                fwd_a_d   = SEL_REGFILE;
                fwd_b_d   = SEL_REGFILE;
                bubble_d  = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                ex_slot_d.rd        = bus.inIdRd;
                ex_slot_d.reg_write = bus.inIdRegWrite;
                ex_slot_d.mem_read  = bus.inIdMemRead;
                fwd_a_d             = sel_a;
                fwd_b_d             = sel_b;
                bubble_d            = 1'b0;
            end
        endcase
    end

    // State registers. Reset empties the pipeline shadow and marks EX as
    // holding a bubble; it overrides any flush or stall in the same cycle.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            ex_slot_q  <= EMPTY_SLOT;
            mem_slot_q <= EMPTY_SLOT;
            fwd_a_q    <= SEL_REGFILE;
            fwd_b_q    <= SEL_REGFILE;
            bubble_q   <= 1'b1;
            count_q    <= '0;
        end else begin
            ex_slot_q  <= ex_slot_d;
            mem_slot_q <= mem_slot_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            bubble_q   <= bubble_d;
            count_q    <= count_d;
        end
    end

    // The stall request is suppressed by reset so a reset cycle never
    // freezes the front end.
    assign bus.outStall      = hz && !bus.inFlush && !inReset;
    assign bus.outForwardA   = fwd_a_q;
    assign bus.outForwardB   = fwd_b_q;
    assign bus.outBubble     = bubble_q;
    assign bus.outStallCount = count_q;

endmodule

// File: tb/tb_ex_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_forward_unit
//
// Self-checking bench for ex_forward_unit. A reference model keeps the list
// of in-flight instructions (newest first) and derives stall, selects,
// bubble flag and stall count from the pipeline rules. The counter is
// narrowed so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_ex_forward_unit;

    localparam int REG_BITS = 5;
    localparam int CNT_BITS = 6;
    localparam int CNT_MAX  = (1 << CNT_BITS) - 1;

    typedef struct {
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    logic inClk;
    logic inReset;

    ex_forward_unit_if #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) bus ();

    ex_forward_unit #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) dut (
        .inClk   (inClk),
        .inReset (inReset),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    instr_t     hist[$];
    logic [1:0] exp_fa;
    logic [1:0] exp_fb;
    logic       exp_bubble;
    int         exp_cnt;
    logic       exp_stall;
    logic       obs_stall;

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Which older instruction (0 = one ahead, 1 = two ahead) produces src.
    function automatic logic [1:0] model_sel(input bit uses, input int src);
        for (int d = 0; d < hist.size() && d < 2; d++) begin
            if (uses && hist[d].rw && hist[d].rd != 0 && hist[d].rd == src)
                return (d == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic bit model_load_use(input bit urs, input int rs, input bit urt, input int rt);
        if (hist.size() == 0) return 1'b0;
        if (!(hist[0].mr && hist[0].rw && hist[0].rd != 0)) return 1'b0;
        return (urs && rs == hist[0].rd) || (urt && rt == hist[0].rd);
    endfunction

    // Drives one cycle, records the pre-edge stall output and advances the model.
    task automatic cycle(input bit rst, input bit flush,
                         input int rs, input bit urs, input int rt, input bit urt,
                         input int rd, input bit rw, input bit mr);
        instr_t nw;
        instr_t empty_i;
        empty_i = '{rd: 0, rw: 1'b0, mr: 1'b0};
        inReset          = rst;
        bus.inFlush      = flush;
        bus.inIdRs       = REG_BITS'(rs);
        bus.inIdRt       = REG_BITS'(rt);
        bus.inIdUsesRs   = urs;
        bus.inIdUsesRt   = urt;
        bus.inIdRd       = REG_BITS'(rd);
        bus.inIdRegWrite = rw;
        bus.inIdMemRead  = mr;
        #1;
        exp_stall = !rst && !flush && model_load_use(urs, rs, urt, rt);
        obs_stall = bus.outStall;
        @(posedge inClk);
        #1;
        if (rst) begin
            hist.delete();
            hist.push_front(empty_i);
            hist.push_front(empty_i);
            exp_fa = 2'b00; exp_fb = 2'b00; exp_bubble = 1'b1; exp_cnt = 0;
        end else if (flush || exp_stall) begin
            exp_fa = 2'b00; exp_fb = 2'b00; exp_bubble = 1'b1;
            if (exp_stall && exp_cnt < CNT_MAX) exp_cnt++;
            hist.push_front(empty_i);
        end else begin
            exp_fa = model_sel(urs, rs);
            exp_fb = model_sel(urt, rt);
            exp_bubble = 1'b0;
            nw = '{rd: rd, rw: rw, mr: mr};
            hist.push_front(nw);
        end
        while (hist.size() > 2) void'(hist.pop_back());
    endtask

    task automatic issue(input int rs, input bit urs, input int rt, input bit urt,
                         input int rd, input bit rw, input bit mr);
        cycle(1'b0, 1'b0, rs, urs, rt, urt, rd, rw, mr);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.outForwardA !== 2'b00) begin failures++; $display("[TB] FAIL reset_fwdA: got %b expected 00", bus.outForwardA); end
        checks++; if (bus.outForwardB !== 2'b00) begin failures++; $display("[TB] FAIL reset_fwdB: got %b expected 00", bus.outForwardB); end
        checks++; if (bus.outBubble !== 1'b1) begin failures++; $display("[TB] FAIL reset_bubble: got %b expected 1", bus.outBubble); end
        checks++; if (bus.outStallCount !== '0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.outStallCount); end
        issue(7, 1'b1, 7, 1'b1, 0, 1'b0, 1'b0);
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", obs_stall); end
    endtask

    task automatic test_ex_forward();
        do_reset();
        issue(1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);   // add $3
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL exfwd_stall0: got %b expected 0", obs_stall); end
        issue(3, 1'b1, 4, 1'b1, 6, 1'b1, 1'b0);   // sub $6,$3,$4
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL exfwd_stall1: got %b expected 0", obs_stall); end
        checks++; if (bus.outForwardA !== 2'b10) begin failures++; $display("[TB] FAIL exfwd_A: got %b expected 10", bus.outForwardA); end
        checks++; if (bus.outForwardB !== 2'b00) begin failures++; $display("[TB] FAIL exfwd_B: got %b expected 00", bus.outForwardB); end
    endtask

    task automatic test_mem_forward();
        do_reset();
        issue(1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0);   // add $5
        issue(0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);   // nop
        issue(8, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);   // or rt=5
        checks++; if (bus.outForwardB !== 2'b01) begin failures++; $display("[TB] FAIL memfwd_B: got %b expected 01", bus.outForwardB); end
        checks++; if (bus.outForwardA !== 2'b00) begin failures++; $display("[TB] FAIL memfwd_A: got %b expected 00", bus.outForwardA); end
        issue(1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0);   // add $5
        issue(3, 1'b1, 4, 1'b1, 5, 1'b1, 1'b0);   // add $5
        issue(8, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);   // or rt=5
        checks++; if (bus.outForwardB !== 2'b10) begin failures++; $display("[TB] FAIL priority_B: got %b expected 10", bus.outForwardB); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);   // lw $7
        issue(7, 1'b1, 2, 1'b1, 10, 1'b1, 1'b0);  // and rs=7
        checks++; if (obs_stall !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall: got %b expected 1", obs_stall); end
        checks++; if (bus.outBubble !== 1'b1) begin failures++; $display("[TB] FAIL lu_bubble: got %b expected 1", bus.outBubble); end
        checks++; if (bus.outForwardA !== 2'b00) begin failures++; $display("[TB] FAIL lu_fwdA_bubble: got %b expected 00", bus.outForwardA); end
        checks++; if (bus.outStallCount !== 6'd1) begin failures++; $display("[TB] FAIL lu_count: got %0d expected 1", bus.outStallCount); end
        issue(7, 1'b1, 2, 1'b1, 10, 1'b1, 1'b0);  // and re-evaluated
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL lu_stall_once: got %b expected 0", obs_stall); end
        checks++; if (bus.outForwardA !== 2'b01) begin failures++; $display("[TB] FAIL lu_fwdA: got %b expected 01", bus.outForwardA); end
        checks++; if (bus.outBubble !== 1'b0) begin failures++; $display("[TB] FAIL lu_bubble_clear: got %b expected 0", bus.outBubble); end
        // Back-to-back loads to different registers: no stall
        issue(1, 1'b1, 0, 1'b0, 11, 1'b1, 1'b1);  // lw $11
        issue(2, 1'b1, 0, 1'b0, 12, 1'b1, 1'b1);  // lw $12 (base $2)
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL lu_b2b_loads: got %b expected 0", obs_stall); end
    endtask

    task automatic test_zero_and_flush();
        do_reset();
        issue(1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0);   // add $0
        issue(0, 1'b1, 0, 1'b1, 4, 1'b1, 1'b0);   // use $0
        checks++; if (bus.outForwardA !== 2'b00) begin failures++; $display("[TB] FAIL zero_fwdA: got %b expected 00", bus.outForwardA); end
        checks++; if (bus.outForwardB !== 2'b00) begin failures++; $display("[TB] FAIL zero_fwdB: got %b expected 00", bus.outForwardB); end
        issue(1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);   // lw $7
        cycle(1'b0, 1'b1, 7, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0); // dependent, flushed
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL flush_stall: got %b expected 0", obs_stall); end
        checks++; if (bus.outBubble !== 1'b1) begin failures++; $display("[TB] FAIL flush_bubble: got %b expected 1", bus.outBubble); end
        checks++; if (bus.outStallCount !== 6'd0) begin failures++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.outStallCount); end
        // The load reached MEM; a later reader of $7 gets the writeback path
        issue(7, 1'b1, 0, 1'b0, 8, 1'b1, 1'b0);
        checks++; if (bus.outForwardA !== 2'b01) begin failures++; $display("[TB] FAIL flush_memfwd: got %b expected 01", bus.outForwardA); end
    endtask

    task automatic test_saturation();
        int stall_misses;
        stall_misses = 0;
        do_reset();
        for (int i = 0; i < CNT_MAX; i++) begin
            issue(0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1);  // lw $7
            issue(7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0);  // dependent -> stall
            if (obs_stall !== 1'b1) stall_misses++;
        end
        checks++; if (stall_misses != 0) begin failures++; $display("[TB] FAIL sat_stalls: got %0d missing stalls expected 0", stall_misses); end
        checks++; if (int'(bus.outStallCount) != CNT_MAX) begin failures++; $display("[TB] FAIL sat_full: got %0d expected %0d", bus.outStallCount, CNT_MAX); end
        issue(0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1);
        issue(0, 1'b0, 7, 1'b1, 9, 1'b1, 1'b0);
        checks++; if (obs_stall !== 1'b1) begin failures++; $display("[TB] FAIL sat_extra_stall: got %b expected 1", obs_stall); end
        checks++; if (int'(bus.outStallCount) != CNT_MAX) begin failures++; $display("[TB] FAIL sat_hold: got %0d expected %0d", bus.outStallCount, CNT_MAX); end
    endtask

    task automatic test_mid_stall_reset();
        do_reset();
        issue(1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);   // lw $7
        issue(7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0);   // stall
        issue(1, 1'b1, 0, 1'b0, 7, 1'b1, 1'b1);   // lw $7 again (normal)
        cycle(1'b1, 1'b0, 7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0); // reset during hazard
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall_gate: got %b expected 0", obs_stall); end
        checks++; if (bus.outStallCount !== 6'd0) begin failures++; $display("[TB] FAIL rst_count: got %0d expected 0", bus.outStallCount); end
        checks++; if (bus.outBubble !== 1'b1) begin failures++; $display("[TB] FAIL rst_bubble: got %b expected 1", bus.outBubble); end
        issue(7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0);
        checks++; if (obs_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_stall: got %b expected 0", obs_stall); end
        checks++; if (bus.outForwardA !== 2'b00) begin failures++; $display("[TB] FAIL rst_slots_empty: got %b expected 00", bus.outForwardA); end
    endtask

    task automatic test_random();
        bit rst, flush, urs, urt, rw, mr;
        int rs, rt, rd;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rs    = $urandom_range(0, 7);
            rt    = $urandom_range(0, 7);
            rd    = $urandom_range(0, 7);
            urs   = ($urandom_range(0, 3) != 0);
            urt   = ($urandom_range(0, 1) != 0);
            rw    = ($urandom_range(0, 3) != 0);
            mr    = rw && ($urandom_range(0, 2) == 0);
            cycle(rst, flush, rs, urs, rt, urt, rd, rw, mr);
            checks++; if (obs_stall !== exp_stall) begin failures++; $display("[TB] FAIL rnd_stall[%0d]: got %b expected %b", i, obs_stall, exp_stall); end
            checks++; if (bus.outForwardA !== exp_fa) begin failures++; $display("[TB] FAIL rnd_fwdA[%0d]: got %b expected %b", i, bus.outForwardA, exp_fa); end
            checks++; if (bus.outForwardB !== exp_fb) begin failures++; $display("[TB] FAIL rnd_fwdB[%0d]: got %b expected %b", i, bus.outForwardB, exp_fb); end
            checks++; if (bus.outBubble !== exp_bubble) begin failures++; $display("[TB] FAIL rnd_bubble[%0d]: got %b expected %b", i, bus.outBubble, exp_bubble); end
            checks++; if (int'(bus.outStallCount) != exp_cnt) begin failures++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, bus.outStallCount, exp_cnt); end
        end
    endtask

    initial begin
        inReset          = 1'b1;
        bus.inFlush      = 1'b0;
        bus.inIdRs       = '0;
        bus.inIdRt       = '0;
        bus.inIdUsesRs   = 1'b0;
        bus.inIdUsesRt   = 1'b0;
        bus.inIdRd       = '0;
        bus.inIdRegWrite = 1'b0;
        bus.inIdMemRead  = 1'b0;
        exp_fa = 2'b00; exp_fb = 2'b00; exp_bubble = 1'b1; exp_cnt = 0;
        exp_stall = 1'b0; obs_stall = 1'b0;

        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_zero_and_flush();
        test_saturation();
        test_mid_stall_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
